// File: rtl/avalon_enforcer_pkg.sv
// Shared types for the Avalon-ST packet guard.
//   state_e   : packet-tracking state (IDLE, IN_MSG, DROP)
//   viol_t    : one bit per protocol violation class
//   viol_count: number of violations raised in one cycle
package avalon_enforcer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_MSG = 2'd1,
    DROP   = 2'd2
  } state_e;

  typedef struct packed {
    logic missing_sop;
    logic unexpected_sop;
    logic oversize;
    logic bad_empty;
  } viol_t;

  // At most two violations coincide, but the sum of all four fits too.
  localparam int VIOL_CNT_W = 3;

  function automatic logic [VIOL_CNT_W-1:0] viol_count(input viol_t v);
    return VIOL_CNT_W'(v.missing_sop) + VIOL_CNT_W'(v.unexpected_sop)
         + VIOL_CNT_W'(v.oversize)    + VIOL_CNT_W'(v.bad_empty);
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST bus bundle.
//   data  : 8*DATA_WIDTH_IN_BYTES bits
//   valid, sop, eop : beat qualifiers
//   empty : unused bytes on the eop beat
//   rdy   : sink ready (driven by the sink)
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
) ();
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;
  logic                             rdy;

  modport master (output data, valid, sop, eop, empty, input  rdy);
  modport slave  (input  data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_enforcer_sat_cnt.sv
// Saturating up-counter.
//   clk, rst : clock and synchronous active-high reset
//   inc      : amount added this cycle
//   cnt      : current value, sticks at all-ones
module avalon_enforcer_sat_cnt #(
  parameter int WIDTH     = 16,
  parameter int INC_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [WIDTH-1:0]     cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH:0]   sum;

  // One extra bit catches the wrap so we can clamp instead.
  always_comb sum = {1'b0, cnt_q} + (WIDTH + 1)'(inc);

  always_ff @(posedge clk) begin
    if (rst)           cnt_q <= '0;
    else if (sum[WIDTH]) cnt_q <= '1;
    else               cnt_q <= sum[WIDTH-1:0];
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/avalon_pkt_guard.sv
// Avalon-ST packet guard: repairs or discards malformed packets from an
// untrusted source. A one-beat hold register delays each beat until its
// successor is seen, so a packet can be closed retroactively with a forced eop.
//   clk, rst            : clock, synchronous active-high reset
//   untrusted_msg       : input stream (slave)
//   enforced_msg        : repaired output stream (master)
//   missing_sop_indi    : pulse, beat outside a packet without sop
//   unexpected_sop_indi : pulse, sop inside an open packet
//   oversize_indi       : pulse, packet hit MAX_MSG_LEN_IN_WORDS without eop
//   bad_empty_indi      : pulse, nonzero empty on a forwarded non-eop beat
//   err_cnt             : saturating total of all violations
module avalon_pkt_guard
  import avalon_enforcer_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES  = 16,
  parameter int MAX_MSG_LEN_IN_WORDS = 64,
  parameter int ERR_CNT_WIDTH        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  avalon_st_if.slave               untrusted_msg,
  avalon_st_if.master              enforced_msg,
  output logic                     missing_sop_indi,
  output logic                     unexpected_sop_indi,
  output logic                     oversize_indi,
  output logic                     bad_empty_indi,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  localparam int DATA_W  = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
  localparam int CNT_W   = $clog2(MAX_MSG_LEN_IN_WORDS + 1);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;    // native or forced
    logic [EMPTY_W-1:0] empty;  // already cleared unless this is a native eop
  } beat_t;

  state_e            state_q, state_d;
  beat_t             hold_q, hold_d, in_beat;
  logic              hold_valid_q, hold_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  viol_t             viol_q, viol_d;
  logic              releasable, in_rdy, accept, release_beat, bad_empty;

  // The held beat's fate is known once it is an eop or a successor is waiting.
  assign releasable   = hold_valid_q && (hold_q.eop || untrusted_msg.valid);
  assign in_rdy       = !rst && (!hold_valid_q || (releasable && enforced_msg.rdy));
  assign accept       = untrusted_msg.valid && in_rdy;
  assign release_beat = !rst && releasable && enforced_msg.rdy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      // NOTE: the hold datapath is reset too, so every output field reads 0 out of reset.
      hold_q       <= '0;
      cnt_q        <= '0;
      viol_q       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      viol_q       <= viol_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    cnt_d        = cnt_q;
    viol_d       = '0;

    in_beat.data  = untrusted_msg.data;
    in_beat.sop   = untrusted_msg.sop;
    in_beat.eop   = untrusted_msg.eop;
    in_beat.empty = untrusted_msg.eop ? untrusted_msg.empty : '0;
    bad_empty     = !untrusted_msg.eop && (untrusted_msg.empty != '0);
    cnt_inc       = cnt_q + CNT_W'(1);

    if (release_beat) hold_valid_d = 1'b0;

    if (accept) begin
      if (untrusted_msg.sop) begin
        // sop always opens a packet; only an already open one is a violation.
        hold_d                = in_beat;
        hold_valid_d          = 1'b1;
        cnt_d                 = CNT_W'(1);
        state_d               = untrusted_msg.eop ? IDLE : IN_MSG;
        viol_d.unexpected_sop = (state_q == IN_MSG);
        viol_d.bad_empty      = bad_empty;
      end else begin
        unique case (state_q)
          IN_MSG: begin
            hold_d       = in_beat;
            hold_valid_d = 1'b1;
            cnt_d        = cnt_inc;
            if (untrusted_msg.eop) begin
              state_d = IDLE;
            end else if (cnt_inc == CNT_W'(MAX_MSG_LEN_IN_WORDS)) begin
              hold_d.eop      = 1'b1;  // empty is already 0 for a non-eop beat
              state_d         = DROP;
              viol_d.oversize = 1'b1;
            end else begin
              viol_d.bad_empty = bad_empty;
            end
          end
          IDLE: begin
            viol_d.missing_sop = 1'b1;
            state_d            = untrusted_msg.eop ? IDLE : DROP;
          end
          default: state_d = untrusted_msg.eop ? IDLE : DROP;
        endcase
      end
    end
  end

  // Outputs
  always_comb begin
    untrusted_msg.rdy  = in_rdy;
    enforced_msg.valid = 1'b0;
    enforced_msg.data  = '0;
    enforced_msg.sop   = 1'b0;
    enforced_msg.eop   = 1'b0;
    enforced_msg.empty = '0;
    if (!rst) begin
      enforced_msg.valid = releasable;
      enforced_msg.data  = hold_q.data;
      enforced_msg.sop   = hold_q.sop;
      // A waiting sop closes the open packet; the held empty is 0 in that case.
      enforced_msg.eop   = hold_q.eop || (untrusted_msg.valid && untrusted_msg.sop);
      enforced_msg.empty = hold_q.empty;
    end
  end

  assign missing_sop_indi    = viol_q.missing_sop;
  assign unexpected_sop_indi = viol_q.unexpected_sop;
  assign oversize_indi       = viol_q.oversize;
  assign bad_empty_indi      = viol_q.bad_empty;

  avalon_enforcer_sat_cnt #(
    .WIDTH     (ERR_CNT_WIDTH),
    .INC_WIDTH (VIOL_CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (viol_count(viol_d)),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_avalon_pkt_guard.sv
module tb_avalon_pkt_guard;

  localparam int DWB = 16;
  localparam int MAX = 4;
  localparam int ECW = 16;
  localparam int DW  = 8 * DWB;
  localparam int EW  = 4;
  localparam int ERR_MAX = (1 << ECW) - 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_s;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) in_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) out_if ();

  logic           missing_sop_indi, unexpected_sop_indi, oversize_indi, bad_empty_indi;
  logic [ECW-1:0] err_cnt;

  avalon_pkt_guard #(
    .DATA_WIDTH_IN_BYTES  (DWB),
    .MAX_MSG_LEN_IN_WORDS (MAX),
    .ERR_CNT_WIDTH        (ECW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .untrusted_msg       (in_if),
    .enforced_msg        (out_if),
    .missing_sop_indi    (missing_sop_indi),
    .unexpected_sop_indi (unexpected_sop_indi),
    .oversize_indi       (oversize_indi),
    .bad_empty_indi      (bad_empty_indi),
    .err_cnt             (err_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  beat_s    m_q[$];        // beats accepted for output, not yet delivered
  bit       m_in_pkt = 0;  // a packet is open
  bit       m_drop   = 0;  // discarding the rest of a fragment
  int       m_cnt    = 0;  // beats in the open packet
  logic [3:0] exp_flags = 4'b0;  // {missing, unexpected, oversize, bad_empty}
  int       exp_err  = 0;

  beat_s    out_log[$];    // beats actually delivered by the DUT
  int       pulses[4];     // indexed like the flag vector bits

  task automatic model_accept(input beat_s b);
    beat_s      o;
    logic [3:0] f;
    int         n;
    o = b;
    f = 4'b0;
    if (m_in_pkt && !b.sop) begin
      m_cnt++;
      if (b.eop) m_in_pkt = 0;
      else if (m_cnt == MAX) begin
        o.eop = 1'b1; o.empty = '0; f[1] = 1'b1; m_in_pkt = 0; m_drop = 1;
      end else if (b.empty != 0) begin
        o.empty = '0; f[0] = 1'b1;
      end
      m_q.push_back(o);
    end else if (b.sop) begin
      if (m_in_pkt && m_q.size() > 0) begin
        m_q[m_q.size()-1].eop   = 1'b1;
        m_q[m_q.size()-1].empty = '0;
        f[2] = 1'b1;
      end
      m_cnt = 1; m_drop = 0; m_in_pkt = !b.eop;
      if (!b.eop && b.empty != 0) begin
        o.empty = '0; f[0] = 1'b1;
      end
      m_q.push_back(o);
    end else begin
      if (!m_drop) f[3] = 1'b1;
      m_drop = !b.eop;
    end
    exp_flags = f;
    n = int'(f[0]) + int'(f[1]) + int'(f[2]) + int'(f[3]);
    exp_err = (exp_err + n > ERR_MAX) ? ERR_MAX : exp_err + n;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [3:0] act_flags;
    logic       exp_valid, exp_rdy;
    beat_s      b, a;
    act_flags = {missing_sop_indi, unexpected_sop_indi, oversize_indi, bad_empty_indi};
    check("indications", 160'(act_flags), 160'(exp_flags));
    check("err_cnt", 160'(err_cnt), 160'(exp_err));
    for (int i = 0; i < 4; i++) if (act_flags[i] === 1'b1) pulses[i]++;
    if (rst) begin
      check("rst_ctrl", 160'({out_if.valid, out_if.sop, out_if.eop, out_if.empty, in_if.rdy}), 160'(0));
      check("rst_data", 160'(out_if.data), 160'(0));
      m_q.delete();
      m_in_pkt = 0; m_drop = 0; m_cnt = 0;
      exp_flags = 4'b0; exp_err = 0;
    end else begin
      exp_valid = (m_q.size() > 0) && (m_q[0].eop || in_if.valid);
      exp_rdy   = (m_q.size() == 0) || (exp_valid && out_if.rdy);
      check("out_valid", 160'(out_if.valid), 160'(exp_valid));
      check("in_rdy", 160'(in_if.rdy), 160'(exp_rdy));
      exp_flags = 4'b0;
      if (in_if.valid && exp_rdy) begin
        b.data = in_if.data; b.sop = in_if.sop; b.eop = in_if.eop; b.empty = in_if.empty;
        model_accept(b);
      end
      a.data = out_if.data; a.sop = out_if.sop; a.eop = out_if.eop; a.empty = out_if.empty;
      if (exp_valid && out_if.rdy && m_q.size() > 0) begin
        b = m_q.pop_front();
        check("out_beat", 160'({a.data, a.sop, a.eop, a.empty}), 160'({b.data, b.sop, b.eop, b.empty}));
      end
      if (out_if.valid && out_if.rdy) out_log.push_back(a);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_scn();
    out_log.delete();
    for (int i = 0; i < 4; i++) pulses[i] = 0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic s, input logic e, input logic [EW-1:0] em);
    bit acc;
    acc = 0;
    in_if.valid = 1'b1; in_if.data = d; in_if.sop = s; in_if.eop = e; in_if.empty = em;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = (in_if.rdy === 1'b1);
      @(posedge clk);
      #1;
    end
    check("send_accepted", 160'(acc), 160'(1));
    in_if.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_if.valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input string name, input int idx, input logic [DW-1:0] d,
                             input logic s, input logic e, input logic [EW-1:0] em);
    check({name, "_present"}, 160'(out_log.size() > idx), 160'(1));
    if (out_log.size() > idx)
      check(name, 160'({out_log[idx].data, out_log[idx].sop, out_log[idx].eop, out_log[idx].empty}),
            160'({d, s, e, em}));
  endtask

  task automatic check_pulses(input string name, input int ms, input int us, input int ov, input int be);
    check(name, 160'({8'(pulses[3]), 8'(pulses[2]), 8'(pulses[1]), 8'(pulses[0])}),
          160'({8'(ms), 8'(us), 8'(ov), 8'(be)}));
  endtask

  task automatic drive_random();
    in_if.valid = ($urandom_range(0, 9) < 7);
    in_if.sop   = ($urandom_range(0, 9) < 3);
    in_if.eop   = ($urandom_range(0, 9) < 3);
    in_if.empty = ($urandom_range(0, 3) == 0) ? EW'($urandom_range(1, 15)) : '0;
    in_if.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    out_if.rdy  = ~out_if.rdy;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    in_if.valid = 1'b0; in_if.sop = 1'b0; in_if.eop = 1'b0; in_if.empty = '0; in_if.data = '0;
    out_if.rdy = 1'b1;
    for (int i = 0; i < 4; i++) pulses[i] = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_err_cnt", 160'(err_cnt), 160'(0));
    check("reset_out_valid", 160'({out_if.valid, in_if.rdy}), 160'(0));
    rst = 1'b0;
    idle(2);

    // Clean 3-beat packet
    start_scn();
    send(DW'(8'h11), 1'b1, 1'b0, 4'h0);
    send(DW'(8'h22), 1'b0, 1'b0, 4'h0);
    send(DW'(8'h33), 1'b0, 1'b1, 4'h0);
    idle(4);
    check("s1_len", 160'(out_log.size()), 160'(3));
    expect_beat("s1_b0", 0, DW'(8'h11), 1'b1, 1'b0, 4'h0);
    expect_beat("s1_b1", 1, DW'(8'h22), 1'b0, 1'b0, 4'h0);
    expect_beat("s1_b2", 2, DW'(8'h33), 1'b0, 1'b1, 4'h0);
    check_pulses("s1_pulses", 0, 0, 0, 0);
    check("s1_err_cnt", 160'(err_cnt), 160'(0));

    // Headless fragment, then clean single-beat packet
    start_scn();
    send(DW'(8'hA1), 1'b0, 1'b0, 4'h0);
    send(DW'(8'hA2), 1'b0, 1'b1, 4'h0);
    send(DW'(8'hB1), 1'b1, 1'b1, 4'h0);
    idle(4);
    check("s2_len", 160'(out_log.size()), 160'(1));
    expect_beat("s2_b0", 0, DW'(8'hB1), 1'b1, 1'b1, 4'h0);
    check_pulses("s2_pulses", 1, 0, 0, 0);
    check("s2_err_cnt", 160'(err_cnt), 160'(1));

    // Unexpected sop closes the open packet
    start_scn();
    send(DW'(8'hC1), 1'b1, 1'b0, 4'h0);
    send(DW'(8'hC2), 1'b0, 1'b0, 4'h0);
    send(DW'(8'hC3), 1'b1, 1'b1, 4'h0);
    idle(4);
    check("s3_len", 160'(out_log.size()), 160'(3));
    expect_beat("s3_b1", 1, DW'(8'hC2), 1'b0, 1'b1, 4'h0);
    expect_beat("s3_b2", 2, DW'(8'hC3), 1'b1, 1'b1, 4'h0);
    check_pulses("s3_pulses", 0, 1, 0, 0);
    check("s3_err_cnt", 160'(err_cnt), 160'(2));

    // Oversize: 6 beats with MAX=4, then a headless beat proves the state is IDLE
    start_scn();
    for (int i = 1; i <= 6; i++) send(DW'(8'hD0 + i), (i == 1), (i == 6), 4'h0);
    send(DW'(8'hE1), 1'b0, 1'b1, 4'h0);
    idle(4);
    check("s4_len", 160'(out_log.size()), 160'(4));
    expect_beat("s4_b3", 3, DW'(8'hD4), 1'b0, 1'b1, 4'h0);
    check_pulses("s4_pulses", 1, 0, 1, 0);
    check("s4_err_cnt", 160'(err_cnt), 160'(4));

    // Bad empty on a middle beat
    start_scn();
    send(DW'(8'hF1), 1'b1, 1'b0, 4'h0);
    send(DW'(8'hF2), 1'b0, 1'b0, 4'hF);
    send(DW'(8'hF3), 1'b0, 1'b1, 4'h3);
    idle(4);
    check("s5_len", 160'(out_log.size()), 160'(3));
    expect_beat("s5_b1", 1, DW'(8'hF2), 1'b0, 1'b0, 4'h0);
    expect_beat("s5_b2", 2, DW'(8'hF3), 1'b0, 1'b1, 4'h3);
    check_pulses("s5_pulses", 0, 0, 0, 1);
    check("s5_err_cnt", 160'(err_cnt), 160'(5));

    // Random traffic with downstream ready toggling
    for (int c = 0; c < 600; c++) begin
      drive_random();
      @(posedge clk);
      #1;
    end

    // Reset while a packet is open and a beat is held
    found = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      drive_random();
      @(posedge clk);
      #1;
      found = m_in_pkt && (m_q.size() > 0);
    end
    check("midpkt_found", 160'(found), 160'(1));
    rst = 1'b1;
    repeat (3) begin
      drive_random();
      @(posedge clk);
      #1;
    end
    check("midpkt_rst_err_cnt", 160'(err_cnt), 160'(0));
    check("midpkt_rst_valid", 160'(out_if.valid), 160'(0));
    rst = 1'b0;
    for (int c = 0; c < 300; c++) begin
      drive_random();
      @(posedge clk);
      #1;
    end

    // Saturation: back-to-back sop beats with bad empty raise two errors each
    out_if.rdy = 1'b1;
    in_if.valid = 1'b1; in_if.sop = 1'b1; in_if.eop = 1'b0; in_if.empty = 4'hF;
    for (int c = 0; c < 34000; c++) begin
      in_if.data = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk);
      #1;
    end
    check("sat_err_cnt", 160'(err_cnt), 160'(16'hFFFF));
    repeat (20) @(posedge clk);
    #1;
    check("sat_err_cnt_hold", 160'(err_cnt), 160'(16'hFFFF));
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
